memd_arb_2: RTL and testbench
=============================

# memd_arb_2

Two-port arbiter that shares the single data-memory port (`memd_1` request/response interface) between two requesters. Requester 0 is the core's load/store stage; requester 1 is a secondary master (loader/DMA/debug). Grant is combinational and same-cycle. Fairness comes from a round-robin priority bit and a bounded lock (burst) mode. It sits between the requesters and `memd_1`, so the memory itself stays unmodified.

## Interface

Parameters:
- `MEMD_SIZE_LOG`, default `` `MEMD_SIZE_LOG ``: data address width.
- `REG_LEN`, default `` `REG_LEN ``: data width.
- `MAX_BURST`, default 4: maximum consecutive locked grants to one owner; legal range 1..15.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `r0_valid`, `r1_valid` in 1: request present.
- `r0_rdwt`, `r1_rdwt` in 1: read/write select, same encoding as `memd_1` `req_rdwt`; passed through uninterpreted.
- `r0_addr`, `r1_addr` in MEMD_SIZE_LOG: request address.
- `r0_data`, `r1_data` in REG_LEN: write data.
- `r0_lock`, `r1_lock` in 1: request to keep the grant on following cycles.
- `r0_ready`, `r1_ready` out 1: grant; the request completes this cycle.
- `r0_resp_data`, `r1_resp_data` out REG_LEN: read data; valid only when that port's ready=1, otherwise 0.
- `mem_valid`, `mem_rdwt` out 1: to `memd_1` `req_valid`/`req_rdwt`.
- `mem_addr` out MEMD_SIZE_LOG, `mem_data` out REG_LEN: to `memd_1`.
- `mem_resp_data` in REG_LEN: from `memd_1` `resp_data` (combinational read).

## Operation

State:
- `state` ∈ {ARB, BURST}.
- `owner` (1 bit).
- `last_grant` (1 bit).
- `burst_cnt` (4 bits).

Reset values: state=ARB, owner=0, last_grant=1 (r0 wins the first tie), burst_cnt=0.

Grant selection (combinational, while `rst`=0):
- ARB, one valid: grant it.
- ARB, both valid: grant `~last_grant`.
- ARB, none valid: no grant; `mem_valid`=0.
- BURST, `owner` valid: grant `owner` unconditionally, even if the other port is valid.
- BURST, `owner` not valid: fall back to the ARB rules.

Mux:
- `mem_*` take the granted port's fields. `mem_valid`=1 iff a grant occurred.
- With no grant, `mem_addr`/`mem_data`/`mem_rdwt` are 0.
- `rX_ready` = (grant==X). `rX_resp_data` = `mem_resp_data` when `rX_ready`, else 0.
- At most one ready is high per cycle.

State update at posedge (only if a grant g occurred; otherwise state is held, except for the BURST exit rule):
- `last_grant` <= g.
- ARB → BURST when `g_lock`=1 and MAX_BURST>1. Set owner<=g and burst_cnt<=1.
- BURST, g==owner, `owner_lock`=1, burst_cnt+1 < MAX_BURST: stay in BURST; burst_cnt++.
- BURST, g==owner, and (`owner_lock`=0 or burst_cnt+1 == MAX_BURST): → ARB; burst_cnt<=0. `last_grant`=owner, so the other port wins the next tie.
- BURST with owner not valid (whether or not the other port was granted): → ARB; burst_cnt<=0.
- Lock asserted on a cycle without a grant has no effect.

Requester obligation:
- A requester with valid=1 and ready=0 holds valid/addr/data/rdwt/lock stable until ready.
- The arbiter does not check this; violations are bench errors.

## Timing

- Zero-cycle latency: request and grant, memory access, and read data all occur in the same cycle. Writes commit at the posedge of the granted cycle (a `memd_1` property).
- `rst`=1 forces `r0_ready`=`r1_ready`=`mem_valid`=0, all data outputs to 0, and a state reset at that posedge. Reset during BURST aborts the burst; the next cycle is ARB with r0 priority.
- Worst-case wait for a valid requester: MAX_BURST cycles (other port bursting) + 1.
- Simultaneous exit and arbitration: on the cycle BURST ends, the next cycle arbitrates with the other port prioritized.

## Test plan

- Reset, then both ports valid for 4 cycles with lock=0: grants r0, r1, r0, r1. `mem_addr` alternates between the two addresses.
- r0 only, read at addr 5 holding 0xA5: `r0_ready`=1 same cycle, `r0_resp_data`=0xA5, `r1_resp_data`=0.
- MAX_BURST=4, r1 valid with lock=1 continuously, r0 valid throughout: r1 granted 4 consecutive cycles, then r0 granted. Next tie goes to r1.
- r0 bursting (lock=1) drops lock after 2 grants while r1 waits: r1 granted on cycle 3. `burst_cnt` returns to 0.
- `rst` asserted mid-burst at grant 2: that cycle has no ready and `mem_valid`=0. The next cycle with both valid grants r0.
- r1 write 0x3C to addr 7 while r0 reads addr 7 in the following cycle: r0 reads 0x3C (write committed at the previous edge).

Source files
------------

// File: rtl/memd_arb_2.sv
// rtl/memd_arb_2.sv - two-port round-robin arbiter with bounded lock bursts in front of memd_1
//
// Shares one memd_1 request port between requester 0 (load/store stage) and
// requester 1 (loader/DMA/debug). Grant is combinational and same-cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rX_valid/rdwt/addr/data  request from port X (X = 0, 1)
//   rX_lock                  ask to keep the grant on following cycles
//   rX_ready                 grant; the request completes this cycle
//   rX_resp_data             read data, zero when rX_ready is low
//   mem_valid/rdwt/addr/data request to memd_1
//   mem_resp_data            combinational read data from memd_1

`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 8
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module memd_arb_2 #(
    parameter int MEMD_SIZE_LOG = `MEMD_SIZE_LOG,
    parameter int REG_LEN       = `REG_LEN,
    parameter int MAX_BURST     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r0_valid,
    input  logic                     r0_rdwt,
    input  logic [MEMD_SIZE_LOG-1:0] r0_addr,
    input  logic [REG_LEN-1:0]       r0_data,
    input  logic                     r0_lock,
    output logic                     r0_ready,
    output logic [REG_LEN-1:0]       r0_resp_data,
    input  logic                     r1_valid,
    input  logic                     r1_rdwt,
    input  logic [MEMD_SIZE_LOG-1:0] r1_addr,
    input  logic [REG_LEN-1:0]       r1_data,
    input  logic                     r1_lock,
    output logic                     r1_ready,
    output logic [REG_LEN-1:0]       r1_resp_data,
    output logic                     mem_valid,
    output logic                     mem_rdwt,
    output logic [MEMD_SIZE_LOG-1:0] mem_addr,
    output logic [REG_LEN-1:0]       mem_data,
    input  logic [REG_LEN-1:0]       mem_resp_data
);

    typedef enum logic {ARB, BURST} state_t;

    // A burst of length one is just a normal grant, so bursts are disabled entirely.
    localparam bit         BURST_EN = (MAX_BURST > 1);
    localparam logic [3:0] MAX_B    = 4'(MAX_BURST);

    state_t     state;
    logic       owner;
    logic       last_grant;
    logic [3:0] burst_cnt;

    logic       gnt_any;
    logic       gnt_sel;
    logic       owner_valid;
    logic       owner_lock;
    logic       gnt_lock;
    logic [3:0] burst_next;

    assign owner_valid = owner ? r1_valid : r0_valid;
    assign owner_lock  = owner ? r1_lock  : r0_lock;
    assign gnt_lock    = gnt_sel ? r1_lock : r0_lock;
    // burst_cnt never exceeds 14, so the increment cannot wrap.
    assign burst_next  = burst_cnt + 4'd1;

    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (!rst) begin
            if (state == BURST && owner_valid) begin
                gnt_any = 1'b1;
                gnt_sel = owner;
            end else if (r0_valid && r1_valid) begin
                gnt_any = 1'b1;
                gnt_sel = ~last_grant;
            end else if (r0_valid) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (r1_valid) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    always_comb begin
        mem_valid = gnt_any;
        mem_rdwt  = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        if (gnt_any) begin
            mem_rdwt = gnt_sel ? r1_rdwt : r0_rdwt;
            mem_addr = gnt_sel ? r1_addr : r0_addr;
            mem_data = gnt_sel ? r1_data : r0_data;
        end
    end

    assign r0_ready     = gnt_any && !gnt_sel;
    assign r1_ready     = gnt_any && gnt_sel;
    assign r0_resp_data = r0_ready ? mem_resp_data : '0;
    assign r1_resp_data = r1_ready ? mem_resp_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            burst_cnt  <= 4'd0;
        end else begin
            if (gnt_any) begin
                last_grant <= gnt_sel;
            end
            case (state)
                ARB: begin
                    if (gnt_any && gnt_lock && BURST_EN) begin
                        state     <= BURST;
                        owner     <= gnt_sel;
                        burst_cnt <= 4'd1;
                    end
                end
                BURST: begin
                    // owner_valid here implies the owner holds this cycle's grant,
                    // and last_grant has just been set to the owner so the other
                    // port wins the next tie after the burst ends.
                    if (owner_valid && owner_lock && (burst_next < MAX_B)) begin
                        burst_cnt <= burst_next;
                    end else begin
                        state     <= ARB;
                        burst_cnt <= 4'd0;
                    end
                end
                default: begin
                    state     <= ARB;
                    burst_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memd_arb_2.sv
// tb/tb_memd_arb_2.sv - directed self-checking bench for memd_arb_2 with behavioural model
module tb_memd_arb_2;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_valid = 1'b0, r0_rdwt = 1'b0, r0_lock = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_data = '0;
    logic          r1_valid = 1'b0, r1_rdwt = 1'b0, r1_lock = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_data = '0;
    logic          r0_ready, r1_ready;
    logic [DW-1:0] r0_resp_data, r1_resp_data;
    logic          mem_valid, mem_rdwt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_resp_data;

    int total = 0;
    int bad   = 0;

    memd_arb_2 #(.MEMD_SIZE_LOG(AW), .REG_LEN(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_rdwt(r0_rdwt), .r0_addr(r0_addr), .r0_data(r0_data),
        .r0_lock(r0_lock), .r0_ready(r0_ready), .r0_resp_data(r0_resp_data),
        .r1_valid(r1_valid), .r1_rdwt(r1_rdwt), .r1_addr(r1_addr), .r1_data(r1_data),
        .r1_lock(r1_lock), .r1_ready(r1_ready), .r1_resp_data(r1_resp_data),
        .mem_valid(mem_valid), .mem_rdwt(mem_rdwt), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Bench memory: rdwt=1 is a write, committed at the posedge of the granted cycle.
    logic [DW-1:0] tmem [256];
    logic          wr_pend = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    assign mem_resp_data = tmem[mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = '0;
        tmem[5] = 8'hA5;
        forever begin
            @(negedge clk);
            wr_pend = mem_valid && mem_rdwt;
            wr_addr = mem_addr;
            wr_data = mem_data;
            @(posedge clk);
            if (wr_pend) tmem[wr_addr] = wr_data;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who wins the next tie, which port (if any) is in a locked run, and
    // how many grants that run has had.
    int   m_tie   = 0;
    int   m_owner = -1;
    int   m_run   = 0;
    logic run_en  = 1'b1;

    always @(negedge clk) begin : cmp
        int g;
        int v0, v1, l0, l1, ov, ol;
        int ea, ed, er, resp;
        if (run_en) begin
            v0 = int'(r0_valid); v1 = int'(r1_valid);
            l0 = int'(r0_lock);  l1 = int'(r1_lock);
            ov = (m_owner == 0) ? v0 : (m_owner == 1) ? v1 : 0;
            ol = (m_owner == 0) ? l0 : (m_owner == 1) ? l1 : 0;
            g = 2;
            if (!rst) begin
                if (ov == 1)              g = m_owner;
                else if (v0 == 1 && v1 == 1) g = m_tie;
                else if (v0 == 1)         g = 0;
                else if (v1 == 1)         g = 1;
            end
            ea = (g == 0) ? int'(r0_addr) : (g == 1) ? int'(r1_addr) : 0;
            ed = (g == 0) ? int'(r0_data) : (g == 1) ? int'(r1_data) : 0;
            er = (g == 0) ? int'(r0_rdwt) : (g == 1) ? int'(r1_rdwt) : 0;
            resp = (g == 2) ? 0 : int'(tmem[ea]);
            chk("m_r0_ready", int'(r0_ready), (g == 0) ? 1 : 0);
            chk("m_r1_ready", int'(r1_ready), (g == 1) ? 1 : 0);
            chk("m_mem_valid", int'(mem_valid), (g != 2) ? 1 : 0);
            chk("m_mem_addr", int'(mem_addr), ea);
            chk("m_mem_data", int'(mem_data), ed);
            chk("m_mem_rdwt", int'(mem_rdwt), er);
            chk("m_r0_resp", int'(r0_resp_data), (g == 0) ? resp : 0);
            chk("m_r1_resp", int'(r1_resp_data), (g == 1) ? resp : 0);
            if (rst) begin
                m_tie = 0; m_owner = -1; m_run = 0;
            end else begin
                if (g != 2) m_tie = 1 - g;
                if (m_owner >= 0) begin
                    if (ov == 1) begin
                        m_run++;
                        if (ol == 0 || m_run >= MB) begin
                            m_owner = -1; m_run = 0;
                        end
                    end else begin
                        m_owner = -1; m_run = 0;
                    end
                end else if (g != 2 && ((g == 0) ? l0 : l1) == 1 && MB > 1) begin
                    m_owner = g; m_run = 1;
                end
            end
        end
    end

    task automatic set_req(input int p, input logic v, input logic lk, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            r0_valid = v; r0_lock = lk; r0_rdwt = wr; r0_addr = a; r0_data = d;
        end else begin
            r1_valid = v; r1_lock = lk; r1_rdwt = wr; r1_addr = a; r1_data = d;
        end
    endtask

    // eg: expected granted port (2 = none); er: expected read data on the granted port.
    task automatic cyc(input string nm, input int eg, input int er);
        @(negedge clk);
        chk({nm, "_r0_ready"}, int'(r0_ready), (eg == 0) ? 1 : 0);
        chk({nm, "_r1_ready"}, int'(r1_ready), (eg == 1) ? 1 : 0);
        chk({nm, "_mem_valid"}, int'(mem_valid), (eg != 2) ? 1 : 0);
        if (eg == 0) chk({nm, "_r0_resp"}, int'(r0_resp_data), er);
        if (eg == 1) chk({nm, "_r1_resp"}, int'(r1_resp_data), er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with both ports requesting
        set_req(0, 1, 0, 0, 8'h10, 8'h00);
        set_req(1, 1, 0, 0, 8'h20, 8'h00);
        rst = 1'b1;
        cyc("reset", 2, 0);
        @(negedge clk);
        chk("reset_mem_addr", int'(mem_addr), 0);
        chk("reset_r0_resp", int'(r0_resp_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // round robin without lock
        cyc("rr0", 0, 0);
        cyc("rr1", 1, 0);
        cyc("rr2", 0, 0);
        cyc("rr3", 1, 0);

        // r0 alone reads addr 5
        set_req(1, 0, 0, 0, 8'h00, 8'h00);
        set_req(0, 1, 0, 0, 8'h05, 8'h00);
        @(negedge clk);
        chk("rd5_r1_resp", int'(r1_resp_data), 0);
        chk("rd5_mem_addr", int'(mem_addr), 5);
        @(posedge clk); #1;
        cyc("rd5", 0, 8'hA5);

        // r1 locks continuously against a waiting r0: four grants then r0
        set_req(0, 1, 0, 0, 8'h10, 8'h00);
        set_req(1, 1, 1, 0, 8'h20, 8'h00);
        cyc("b1_0", 1, 0);
        cyc("b1_1", 1, 0);
        cyc("b1_2", 1, 0);
        cyc("b1_3", 1, 0);
        cyc("b1_exit", 0, 0);
        set_req(1, 1, 0, 0, 8'h20, 8'h00);
        cyc("b1_tie", 1, 0);

        // r0 drops lock after its second grant; r1 wins the third cycle
        set_req(0, 1, 1, 0, 8'h10, 8'h00);
        cyc("b0_0", 0, 0);
        set_req(0, 1, 0, 0, 8'h10, 8'h00);
        cyc("b0_1", 0, 0);
        cyc("b0_r1", 1, 0);

        // reset in the middle of a burst
        set_req(0, 1, 1, 0, 8'h10, 8'h00);
        cyc("rb_0", 0, 0);
        rst = 1'b1;
        cyc("rb_rst", 2, 0);
        rst = 1'b0;
        set_req(0, 1, 0, 0, 8'h10, 8'h00);
        cyc("rb_after", 0, 0);

        // r1 writes 0x3C to addr 7, r0 reads it back next cycle
        set_req(0, 0, 0, 0, 8'h00, 8'h00);
        set_req(1, 1, 0, 1, 8'h07, 8'h3C);
        cyc("wr7", 1, 0);
        set_req(1, 0, 0, 0, 8'h00, 8'h00);
        set_req(0, 1, 0, 0, 8'h07, 8'h00);
        cyc("rd7", 0, 8'h3C);

        // idle
        set_req(0, 0, 0, 0, 8'h00, 8'h00);
        cyc("idle", 2, 0);

        // burst owner goes away: fall back to arbitration, burst ends
        set_req(1, 1, 1, 0, 8'h30, 8'h00);
        cyc("fb_0", 1, 0);
        set_req(1, 0, 0, 0, 8'h00, 8'h00);
        set_req(0, 1, 0, 0, 8'h11, 8'h00);
        cyc("fb_1", 0, 0);
        set_req(1, 1, 0, 0, 8'h31, 8'h00);
        cyc("fb_2", 1, 0);

        set_req(0, 0, 0, 0, 8'h00, 8'h00);
        set_req(1, 0, 0, 0, 8'h00, 8'h00);
        cyc("end", 2, 0);
        run_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
